// File: rtl/dtree_pkg.sv
// Shared dtree definitions: default field widths, the default record layout
// and a helper that sizes a {timestamp, level, path} record.
package dtree_pkg;

  localparam int unsigned DTREE_LEVEL_WIDTH = 2;
  localparam int unsigned DTREE_PATH_WIDTH  = 2;
  localparam int unsigned DTREE_TS_WIDTH    = 16;
  localparam int unsigned DTREE_DEPTH_LOG2  = 3;

  // Record layout at the default widths: path in the LSBs, timestamp in the MSBs.
  localparam int unsigned PATH_LSB     = 0;
  localparam int unsigned LEVEL_LSB    = PATH_LSB + DTREE_PATH_WIDTH;
  localparam int unsigned TS_LSB       = LEVEL_LSB + DTREE_LEVEL_WIDTH;
  localparam int unsigned RECORD_WIDTH = DTREE_TS_WIDTH + DTREE_LEVEL_WIDTH + DTREE_PATH_WIDTH;

  function automatic int unsigned record_width(input int unsigned ts_w,
                                               input int unsigned level_w,
                                               input int unsigned path_w);
    return ts_w + level_w + path_w;
  endfunction

endpackage

// File: rtl/dtree_label_streamer_if.sv
// Classifier input and record output stream of the label streamer.
// master: the streamer side; slave: the classifier/host side.
interface dtree_label_streamer_if
  import dtree_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH = DTREE_LEVEL_WIDTH,
  parameter int unsigned PATH_WIDTH  = DTREE_PATH_WIDTH,
  parameter int unsigned TS_WIDTH    = DTREE_TS_WIDTH
);
  localparam int unsigned REC_WIDTH = record_width(TS_WIDTH, LEVEL_WIDTH, PATH_WIDTH);

  logic [LEVEL_WIDTH-1:0] in_level;
  logic [PATH_WIDTH-1:0]  in_path;
  logic                   in_valid;
  logic [REC_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  in_level, in_path, in_valid, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output in_level, in_path, in_valid, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/dtree_sync_fifo.sv
// Generic first-word-fall-through FIFO. Head is read combinationally from the
// registered array; fill is an explicit counter. A push while full is accepted
// only when a pop happens in the same cycle.
module dtree_sync_fifo #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (fill == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (fill == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since the head is ignored while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; fill tracks occupancy independently of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fill <= fill + 1'b1;
      else if (do_pop && !do_push) fill <= fill - 1'b1;
    end
  end

endmodule

// File: rtl/dtree_label_streamer.sv
// Timestamps dtree classifications, buffers them in an FWFT FIFO and drains
// them over a valid/ready stream; sticky overflow reports dropped records.
// Optional macro DTREE_STREAM_DROP_CNT_EN adds a saturating 8-bit drop_count.
module dtree_label_streamer
  import dtree_pkg::*;
#(
  parameter int unsigned LEVEL_WIDTH = DTREE_LEVEL_WIDTH,
  parameter int unsigned PATH_WIDTH  = DTREE_PATH_WIDTH,
  parameter int unsigned TS_WIDTH    = DTREE_TS_WIDTH,
  parameter int unsigned DEPTH_LOG2  = DTREE_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  dtree_label_streamer_if.master s,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow,
  input  logic                  clear_overflow
`ifdef DTREE_STREAM_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);
  localparam int unsigned REC_WIDTH = record_width(TS_WIDTH, LEVEL_WIDTH, PATH_WIDTH);

  logic [TS_WIDTH-1:0]  timestamp;
  logic [REC_WIDTH-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign pop         = !empty && s.out_ready;
  assign push        = s.in_valid && (!full || pop);
  assign drop        = s.in_valid && full && !pop;
  assign wr_data     = {timestamp, s.in_level, s.in_path};
  assign s.out_valid = !empty;

  // Free-running sample-time counter, one tick per sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) timestamp <= '0;
    else       timestamp <= timestamp + 1'b1;
  end

  // Sticky loss flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

`ifdef DTREE_STREAM_DROP_CNT_EN
  // Saturating drop counter; a drop coinciding with a clear restarts it at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clear_overflow)         drop_count <= 8'd1;
      else if (drop_count != '1)  drop_count <= drop_count + 1'b1;
    end else if (clear_overflow) begin
      drop_count <= '0;
    end
  end
`endif

  dtree_sync_fifo #(
    .WIDTH      (REC_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (s.out_data),
    .fill    (fill),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_dtree_label_streamer.sv
// Directed bench for dtree_label_streamer with a queue scoreboard and a
// reference timestamp counter; optional DTREE_STREAM_DROP_CNT_EN checks drop_count.
module tb_dtree_label_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fill;
  logic       overflow;
  logic       clear_overflow = 1'b0;
`ifdef DTREE_STREAM_DROP_CNT_EN
  logic [7:0] drop_count;
  int unsigned exp_dc = 0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [19:0] q[$];
  logic [15:0] ts_model;
  logic        exp_ovf = 1'b0;

  dtree_label_streamer_if #(.LEVEL_WIDTH(2), .PATH_WIDTH(2), .TS_WIDTH(16)) bif ();

  dtree_label_streamer #(
    .LEVEL_WIDTH (2),
    .PATH_WIDTH  (2),
    .TS_WIDTH    (16),
    .DEPTH_LOG2  (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s              (bif.master),
    .fill           (fill),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef DTREE_STREAM_DROP_CNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference sample-time counter.
  always @(posedge clk or posedge reset) begin
    if (reset) ts_model <= '0;
    else       ts_model <= ts_model + 16'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check against the scoreboard, update it, clock.
  task automatic cycle(input logic v, input logic [1:0] lv, input logic [1:0] pt,
                       input logic rdy, input logic clr);
    int unsigned n;
    logic do_pop, do_push, do_drop;
    bif.in_valid   = v;
    bif.in_level   = lv;
    bif.in_path    = pt;
    bif.out_ready  = rdy;
    clear_overflow = clr;
    #1;
    n = q.size();
    check("fill", 32'(fill), n);
    check("out_valid", 32'(bif.out_valid), 32'(n != 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
`ifdef DTREE_STREAM_DROP_CNT_EN
    check("drop_count", 32'(drop_count), exp_dc);
`endif
    do_pop  = (n != 0) && rdy;
    do_push = v && ((n < 8) || do_pop);
    do_drop = v && !do_push;
    if (do_pop) begin
      check("out_data", 32'(bif.out_data), 32'(q[0]));
      void'(q.pop_front());
    end
    if (do_push) q.push_back({ts_model, lv, pt});
    if (do_drop)  exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
`ifdef DTREE_STREAM_DROP_CNT_EN
    if (do_drop) exp_dc = clr ? 1 : ((exp_dc == 255) ? 255 : exp_dc + 1);
    else if (clr) exp_dc = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] rec;
    bif.in_valid  = 1'b0;
    bif.in_level  = 2'd0;
    bif.in_path   = 2'd0;
    bif.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_fill", 32'(fill), 0);
    check("rst_out_valid", 32'(bif.out_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
`ifdef DTREE_STREAM_DROP_CNT_EN
    check("rst_drop_count", 32'(drop_count), 0);
`endif
    #2 reset = 1'b0;

    // Single event at timestamp 5
    while (ts_model != 16'd5) cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 2'd1, 1'b0, 1'b0);
    rec = {16'd5, 2'd2, 2'd1};
    check("single_data", 32'(bif.out_data), 32'(rec));
    check("single_fill", 32'(fill), 1);
    cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Fill to full under backpressure, then one drop
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'(i), 2'(i + 1), 1'b0, 1'b0);
    check("full_fill", 32'(fill), 8);
    check("full_no_ovf", 32'(overflow), 0);
    cycle(1'b1, 2'd3, 2'd3, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_fill", 32'(fill), 8);

    // Push and pop together while full
    cycle(1'b1, 2'd1, 2'd2, 1'b1, 1'b0);
    check("fullpop_fill", 32'(fill), 8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

    // Overflow clear alone, then clear coinciding with a drop
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    check("clear_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'(i + 2), 2'(i), 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 2'd3, 1'b0, 1'b1);
    check("clear_drop_ovf", 32'(overflow), 1);
`ifdef DTREE_STREAM_DROP_CNT_EN
    check("clear_drop_cnt", 32'(drop_count), 1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    check("drop_cnt_sat", 32'(drop_count), 255);
`endif
    for (int i = 0; i < 9; i++) cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

    // Timestamp wrap (fifo empty; idle without per-cycle checks)
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    while (ts_model != 16'hFFFF) begin
      @(posedge clk);
      #1;
    end
    cycle(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 2'd2, 1'b0, 1'b0);
    rec = {16'hFFFF, 2'd1, 2'd3};
    check("wrap_first", 32'(bif.out_data), 32'(rec));
    cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    rec = {16'd1, 2'd3, 2'd2};
    check("wrap_second", 32'(bif.out_data), 32'(rec));
    cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd2, 2'(i), 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill), 5);
    check("pre_rst_valid", 32'(bif.out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(bif.out_valid), 0);
    check("async_rst_fill", 32'(fill), 0);
    q.delete();
    exp_ovf = 1'b0;
`ifdef DTREE_STREAM_DROP_CNT_EN
    exp_dc = 0;
`endif
    #2 reset = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_level  = 2'd1;
    bif.in_path   = 2'd1;
    bif.out_ready = 1'b0;
    #1;
    check("post_rst_fill", 32'(fill), 0);
    q.push_back({ts_model, 2'd1, 2'd1});
    @(posedge clk);
    #1;
    rec = {16'd0, 2'd1, 2'd1};
    check("post_rst_ts0", 32'(bif.out_data), 32'(rec));
    cycle(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    cycle(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
